// File: rtl/csi_rx_packet_parser.sv
// CSI-2 receive packet parser: header ECC check/correction, long-packet payload
// extraction with byte enables, and truncation detection on a 32-bit merged-lane stream.
module csi_rx_packet_parser (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] DIN,
   input  logic        DIN_VALID,
   output logic        HDR_VALID,
   output logic [1:0]  VC,
   output logic [5:0]  DT,
   output logic [15:0] WC,
   output logic        ECC_CORR,
   output logic        ECC_ERR,
   output logic [31:0] DOUT,
   output logic [3:0]  DOUT_KEEP,
   output logic        DOUT_VALID,
   output logic        DOUT_LAST,
   output logic        TRUNC_ERR,
   output logic [1:0]  STATE
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PAYLOAD = 2'd1,
      DRAIN   = 2'd2
   } state_t;

   // Data-bit membership of each ECC parity equation (bit i set = DIN[i] participates).
   localparam logic [23:0] M0 = 24'hF12CB7;
   localparam logic [23:0] M1 = 24'hF2555B;
   localparam logic [23:0] M2 = 24'h749A6D;
   localparam logic [23:0] M3 = 24'hB8E38E;
   localparam logic [23:0] M4 = 24'hDF03F0;
   localparam logic [23:0] M5 = 24'hEFFC00;

   state_t      state, state_next;
   logic [15:0] rem, rem_next;

   logic [5:0]  ecc_calc;
   logic [5:0]  syndrome;
   logic [23:0] hdr_fix;
   logic        col_hit;
   logic        hdr_corr;
   logic        hdr_bad;

   logic        take_hdr;
   logic        take_err;
   logic        take_word;
   logic [3:0]  word_keep;
   logic        word_last;
   logic        trunc;

   always_comb begin
      ecc_calc = {^(DIN[23:0] & M5), ^(DIN[23:0] & M4), ^(DIN[23:0] & M3),
                  ^(DIN[23:0] & M2), ^(DIN[23:0] & M1), ^(DIN[23:0] & M0)};
      syndrome = ecc_calc ^ DIN[29:24];
      hdr_fix  = DIN[23:0];
      col_hit  = 1'b0;
      // A syndrome equal to a data column identifies the single flipped data bit.
      for (int i = 0; i < 24; i++) begin
         if (syndrome == {M5[i], M4[i], M3[i], M2[i], M1[i], M0[i]}) begin
            hdr_fix[i] = ~DIN[i];
            col_hit    = 1'b1;
         end
      end
      hdr_corr = col_hit || $onehot(syndrome);
      hdr_bad  = (syndrome != 6'd0) && !hdr_corr;
   end

   always_comb begin
      state_next = state;
      rem_next   = rem;
      take_hdr   = 1'b0;
      take_err   = 1'b0;
      take_word  = 1'b0;
      word_keep  = 4'hF;
      word_last  = 1'b0;
      trunc      = 1'b0;
      case (state)
         IDLE: begin
            if (DIN_VALID) begin
               if (hdr_bad) begin
                  take_err   = 1'b1;
                  state_next = DRAIN;
               end else begin
                  take_hdr = 1'b1;
                  if (hdr_fix[5:0] <= 6'h0F || hdr_fix[23:8] == 16'd0) begin
                     state_next = DRAIN;
                  end else begin
                     state_next = PAYLOAD;
                     rem_next   = hdr_fix[23:8];
                  end
               end
            end
         end
         PAYLOAD: begin
            if (DIN_VALID) begin
               take_word = 1'b1;
               if (rem > 16'd4) begin
                  rem_next = rem - 16'd4;
               end else begin
                  // Bytes past the remaining count (CRC footer, padding) are masked off.
                  word_keep  = 4'((5'd1 << rem[2:0]) - 5'd1);
                  word_last  = 1'b1;
                  rem_next   = 16'd0;
                  state_next = DRAIN;
               end
            end else begin
               trunc      = 1'b1;
               rem_next   = 16'd0;
               state_next = IDLE;
            end
         end
         DRAIN: begin
            if (!DIN_VALID) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= IDLE;
         rem        <= 16'd0;
         HDR_VALID  <= 1'b0;
         ECC_CORR   <= 1'b0;
         ECC_ERR    <= 1'b0;
         VC         <= 2'd0;
         DT         <= 6'd0;
         WC         <= 16'd0;
         DOUT       <= 32'd0;
         DOUT_KEEP  <= 4'd0;
         DOUT_VALID <= 1'b0;
         DOUT_LAST  <= 1'b0;
         TRUNC_ERR  <= 1'b0;
      end else begin
         state      <= state_next;
         rem        <= rem_next;
         HDR_VALID  <= take_hdr;
         ECC_CORR   <= take_hdr && hdr_corr;
         ECC_ERR    <= take_err;
         DOUT_VALID <= take_word;
         DOUT_LAST  <= word_last;
         TRUNC_ERR  <= trunc;
         if (take_hdr) begin
            WC <= hdr_fix[23:8];
            VC <= hdr_fix[7:6];
            DT <= hdr_fix[5:0];
         end
         if (take_word) begin
            DOUT      <= DIN;
            DOUT_KEEP <= word_keep;
         end
      end
   end

   assign STATE = state;

endmodule
